// File: rtl/cache_writeback_ctrl_if.sv
// Signal bundle between the miss/write-back controller, the cache arrays and the RAM port.
// The master side is the controller. The slave side is the cache and the RAM.
interface cache_writeback_ctrl_if #(
  parameter int TAG_W  = 8,
  parameter int DATA_W = 8
);
  logic              missReq;
  logic [TAG_W-1:0]  missTag;
  logic [3:0]        dirty;
  logic [TAG_W-1:0]  victimTag;
  logic [DATA_W-1:0] victimData;
  logic [1:0]        victimWay;
  logic              ramReq;
  logic              ramWe;
  logic [TAG_W-1:0]  ramAddr;
  logic [DATA_W-1:0] ramWData;
  logic [DATA_W-1:0] ramRData;
  logic              ramAck;
  logic [3:0]        cacheWe;
  logic              cacheClean;
  logic [TAG_W-1:0]  cacheTag;
  logic [DATA_W-1:0] cacheWData;
  logic              busy;
  logic              done;

  modport master (
    input  missReq, missTag, dirty, victimTag, victimData, ramRData, ramAck,
    output victimWay, ramReq, ramWe, ramAddr, ramWData,
           cacheWe, cacheClean, cacheTag, cacheWData, busy, done
  );

  modport slave (
    output missReq, missTag, dirty, victimTag, victimData, ramRData, ramAck,
    input  victimWay, ramReq, ramWe, ramAddr, ramWData,
           cacheWe, cacheClean, cacheTag, cacheWData, busy, done
  );
endinterface

// File: rtl/cache_writeback_ctrl.sv
// 4-way cache miss controller: round-robin victim, optional dirty write-back, line fill, clean commit.
// Every output is decoded from the registered state and the captured tag/data registers.
module cache_writeback_ctrl #(
  parameter int TAG_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  cache_writeback_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    WB     = 3'd2,
    FILL   = 3'd3,
    COMMIT = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [TAG_W-1:0]  miss_tag_q;
  logic [TAG_W-1:0]  vict_tag_q;
  logic [DATA_W-1:0] vict_data_q;
  logic [DATA_W-1:0] fill_data_q;

  function automatic logic [3:0] way_onehot(input logic [1:0] way);
    logic [3:0] oh;
    oh = 4'b0001 << way;
    return oh;
  endfunction

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Datapath captures carry no reset: every output using them is gated by state.
  always_ff @(posedge clock) begin
    if (state_q == IDLE && bus.missReq) begin
      miss_tag_q <= bus.missTag;
    end
    if (state_q == SELECT) begin
      vict_tag_q  <= bus.victimTag;
      vict_data_q <= bus.victimData;
    end
    if (state_q == FILL && bus.ramAck) begin
      fill_data_q <= bus.ramRData;
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    bus.ramReq     = 1'b0;
    bus.ramWe      = 1'b0;
    bus.ramAddr    = '0;
    bus.ramWData   = '0;
    bus.cacheWe    = 4'b0000;
    bus.cacheClean = 1'b0;
    bus.cacheTag   = '0;
    bus.cacheWData = '0;
    bus.done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.missReq) state_d = SELECT;
      end
      SELECT: begin
        state_d = bus.dirty[ptr_q] ? WB : FILL;
      end
      WB: begin
        bus.ramReq   = 1'b1;
        bus.ramWe    = 1'b1;
        bus.ramAddr  = vict_tag_q;
        bus.ramWData = vict_data_q;
        if (bus.ramAck) state_d = FILL;
      end
      // Write data stays on the bus through the fill so it never glitches while ramReq is high.
      FILL: begin
        bus.ramReq   = 1'b1;
        bus.ramAddr  = miss_tag_q;
        bus.ramWData = vict_data_q;
        if (bus.ramAck) state_d = COMMIT;
      end
      COMMIT: begin
        bus.cacheWe    = way_onehot(ptr_q);
        bus.cacheClean = 1'b1;
        bus.cacheTag   = miss_tag_q;
        bus.cacheWData = fill_data_q;
        bus.done       = 1'b1;
        ptr_d          = ptr_q + 2'd1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.victimWay = ptr_q;

endmodule

// File: tb/tb_cache_writeback_ctrl.sv
// Randomized scoreboard bench for cache_writeback_ctrl: a driver issues misses and pushes the
// expected RAM transactions and commits, a monitor pops and compares as the DUT presents them.
module tb_cache_writeback_ctrl;
  localparam int TAG_W  = 8;
  localparam int DATA_W = 8;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  cache_writeback_ctrl_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bif ();

  cache_writeback_ctrl #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bif)
  );

  // Environment: cache arrays, dirty vector and RAM
  logic       miss_req   = 1'b0;
  logic [7:0] miss_tag   = 8'h00;
  logic [3:0] dirty_v    = 4'h0;
  logic       resp_ack   = 1'b0;
  logic       stray_ack  = 1'b0;
  logic [7:0] resp_rdata = 8'h00;
  logic       ram_hold   = 1'b0;
  int         lat_w      = 0;
  int         lat_r      = 0;
  logic [7:0] c_tags [4];
  logic [7:0] c_data [4];
  logic [7:0] ram_mem [256];

  assign bif.missReq    = miss_req;
  assign bif.missTag    = miss_tag;
  assign bif.dirty      = dirty_v;
  assign bif.victimTag  = c_tags[bif.victimWay];
  assign bif.victimData = c_data[bif.victimWay];
  assign bif.ramAck     = resp_ack | stray_ack;
  assign bif.ramRData   = resp_rdata;

  // Reference model state
  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } ram_exp_t;
  typedef struct packed {
    logic [3:0]  we;
    logic [7:0]  tag;
    logic [7:0]  data;
    logic [31:0] cyc;
  } cm_exp_t;

  ram_exp_t    ram_q [$];
  cm_exp_t     cm_q [$];
  cm_exp_t     mon_e;
  logic [7:0]  ref_tags [4];
  logic [7:0]  ref_data [4];
  logic [7:0]  ref_mem [256];
  int          ref_ptr = 0;
  int          n_cmp   = 0;
  int          n_fail  = 0;
  logic [31:0] cyc     = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_line(input int w, input logic [7:0] t, input logic [7:0] d);
    c_tags[w]   = t;
    c_data[w]   = d;
    ref_tags[w] = t;
    ref_data[w] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ramReq"},     32'(bif.ramReq),     0);
    chk({tag, "_ramWe"},      32'(bif.ramWe),      0);
    chk({tag, "_ramAddr"},    32'(bif.ramAddr),    0);
    chk({tag, "_ramWData"},   32'(bif.ramWData),   0);
    chk({tag, "_cacheWe"},    32'(bif.cacheWe),    0);
    chk({tag, "_cacheClean"}, 32'(bif.cacheClean), 0);
    chk({tag, "_cacheTag"},   32'(bif.cacheTag),   0);
    chk({tag, "_cacheWData"}, 32'(bif.cacheWData), 0);
    chk({tag, "_busy"},       32'(bif.busy),       0);
    chk({tag, "_done"},       32'(bif.done),       0);
    chk({tag, "_victimWay"},  32'(bif.victimWay),  0);
  endtask

  // RAM responder: acks after the configured latency, applies writes, returns read data.
  initial begin : responder
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clock);
      if (resp_ack) begin
        resp_ack = 1'b0;
        cnt      = 0;
      end
      if (!resetn || ram_hold) begin
        cnt = 0;
      end else if (bif.ramReq) begin
        if (cnt >= (bif.ramWe ? lat_w : lat_r)) begin
          resp_ack = 1'b1;
          if (bif.ramWe) ram_mem[bif.ramAddr] = bif.ramWData;
          else           resp_rdata = ram_mem[bif.ramAddr];
        end else begin
          cnt++;
        end
      end
    end
  end

  // Cache arrays absorb whatever the controller commits.
  initial begin : cache_env
    forever begin
      @(posedge clock);
      for (int w = 0; w < 4; w++) begin
        if (bif.cacheWe[w]) begin
          c_tags[w] = bif.cacheTag;
          c_data[w] = bif.cacheWData;
        end
      end
    end
  end

  // Monitor: compares every RAM request cycle and every commit against the queue heads.
  always @(negedge clock) begin
    #1;
    if (resetn) begin
      if (bif.ramReq) begin
        if (ram_q.size() == 0) begin
          chk("ram_unexpected_req", 32'(bif.ramReq), 0);
        end else begin
          chk("ramWe",   32'(bif.ramWe),   32'(ram_q[0].we));
          chk("ramAddr", 32'(bif.ramAddr), 32'(ram_q[0].addr));
          if (ram_q[0].we) chk("ramWData", 32'(bif.ramWData), 32'(ram_q[0].wdata));
          if (bif.ramAck) void'(ram_q.pop_front());
        end
      end
      if (bif.cacheWe != 4'b0000 || bif.done) begin
        if (cm_q.size() == 0) begin
          chk("commit_unexpected", 32'(bif.cacheWe), 0);
        end else begin
          mon_e = cm_q.pop_front();
          chk("cacheWe",     32'(bif.cacheWe),    32'(mon_e.we));
          chk("cacheClean",  32'(bif.cacheClean), 1);
          chk("cacheTag",    32'(bif.cacheTag),   32'(mon_e.tag));
          chk("cacheWData",  32'(bif.cacheWData), 32'(mon_e.data));
          chk("done",        32'(bif.done),       1);
          chk("commit_cyc",  cyc,                 mon_e.cyc);
        end
      end
    end
  end

  // Issue one miss at the current negedge and predict its full effect.
  task automatic do_miss(input logic [7:0] tag, input logic [3:0] dv, input int lw, input int lr,
                         input bit pulse_fill);
    int          way;
    int          t;
    bit          pulsed;
    logic [3:0]  oh;
    logic [7:0]  fetched;
    logic [31:0] exp_cyc;
    way     = ref_ptr;
    dirty_v = dv;
    lat_w   = lw;
    lat_r   = lr;
    if (dv[way]) begin
      ram_q.push_back('{1'b1, ref_tags[way], ref_data[way]});
      ref_mem[ref_tags[way]] = ref_data[way];
    end
    ram_q.push_back('{1'b0, tag, 8'h00});
    fetched = ref_mem[tag];
    exp_cyc = cyc + 32'(dv[way] ? 4 + lw + lr : 3 + lr);
    oh      = 4'b0001 << way;
    cm_q.push_back('{oh, tag, fetched, exp_cyc});
    ref_tags[way] = tag;
    ref_data[way] = fetched;
    ref_ptr       = (ref_ptr + 1) % 4;
    miss_req = 1'b1;
    miss_tag = tag;
    @(negedge clock);
    miss_req = 1'b0;
    miss_tag = 8'($urandom);
    pulsed   = 1'b0;
    t        = 0;
    while (bif.busy && t < 200) begin
      if (miss_req) begin
        miss_req = 1'b0;
      end else if (pulse_fill && !pulsed && bif.ramReq && !bif.ramWe) begin
        miss_req = 1'b1;
        miss_tag = ~tag;
        pulsed   = 1'b1;
      end
      @(negedge clock);
      t++;
    end
    miss_req = 1'b0;
    if (bif.busy) chk("timeout_busy", 32'(bif.busy), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [3:0] dv;
    int         t;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    for (int w = 0; w < 4; w++) set_line(w, 8'($urandom), 8'($urandom));

    resetn = 1'b0;
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    resetn = 1'b1;
    @(negedge clock);

    // Clean miss to 0x12 with fetch latency 2
    ram_mem[8'h12] = 8'hA5;
    ref_mem[8'h12] = 8'hA5;
    do_miss(8'h12, 4'b0000, 0, 2, 1'b0);
    chk("victimWay_after_clean", 32'(bif.victimWay), 32'(ref_ptr));

    // Dirty miss: way 1 holds 0x34/0x5A
    set_line(1, 8'h34, 8'h5A);
    do_miss(8'h56, 4'b0010, 1, 1, 1'b0);
    chk("victimWay_after_dirty", 32'(bif.victimWay), 32'(ref_ptr));

    // Reset while idle, then five clean misses to show the pointer wrap
    resetn = 1'b0;
    @(negedge clock);
    resetn  = 1'b1;
    ref_ptr = 0;
    chk("victimWay_idle_reset", 32'(bif.victimWay), 0);
    for (int k = 0; k < 5; k++) do_miss(8'($urandom), 4'b0000, 0, $urandom_range(0, 2), 1'b0);

    // missReq during FILL and a stray ramAck in IDLE are both ignored
    do_miss(8'($urandom), 4'b0000, 0, 3, 1'b1);
    stray_ack = 1'b1;
    @(negedge clock);
    stray_ack = 1'b0;
    @(negedge clock);
    chk("stray_ack_busy",      32'(bif.busy),      0);
    chk("stray_ack_ramReq",    32'(bif.ramReq),    0);
    chk("stray_ack_victimWay", 32'(bif.victimWay), 32'(ref_ptr));

    // Zero-latency RAM: done three cycles after missReq
    do_miss(8'($urandom), 4'b0000, 0, 0, 1'b0);

    // Randomized misses with random dirty vectors and latencies
    for (int k = 0; k < 40; k++) begin
      dv = 4'($urandom);
      for (int w = 0; w < 4; w++) if (dv[w]) set_line(w, ref_tags[w], 8'($urandom));
      do_miss(8'($urandom), dv, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    // Reset in the middle of a write-back
    set_line(ref_ptr, ref_tags[ref_ptr], 8'($urandom));
    ram_hold = 1'b1;
    dirty_v  = 4'hF;
    ram_q.push_back('{1'b1, ref_tags[ref_ptr], ref_data[ref_ptr]});
    miss_req = 1'b1;
    miss_tag = 8'($urandom);
    @(negedge clock);
    miss_req = 1'b0;
    t = 0;
    while (!(bif.ramReq && bif.ramWe) && t < 20) begin
      @(negedge clock);
      t++;
    end
    chk("wb_reached_ramWe", 32'(bif.ramWe), 1);
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    chk_all_zero("midwb_reset");
    ram_q.delete();
    cm_q.delete();
    ref_ptr  = 0;
    ram_hold = 1'b0;
    resetn   = 1'b1;
    repeat (10) @(negedge clock);
    chk("midwb_busy_after", 32'(bif.busy), 0);

    // Recovery after the abandoned write-back
    for (int k = 0; k < 4; k++) begin
      dv = 4'($urandom);
      do_miss(8'($urandom), dv, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end

    repeat (3) @(negedge clock);
    chk("ram_q_left",    32'(ram_q.size()), 0);
    chk("commit_q_left", 32'(cm_q.size()),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_writeback_ctrl.md
# cache_writeback_ctrl

Miss-handling and write-back controller for the 4-way cache. On a miss it picks a victim way round-robin, writes the victim line back to RAM if its dirty bit is set, fetches the missing line from RAM, and commits it to the cache as a clean line. It is the consumer of the dirty-bit vector and the source of the clean-write pulses that clear it. It sits between the cache arrays and the RAM port.

## Interface
- TAG_W, default 8: line address / tag width; RAM is line-addressed.
- DATA_W, default 8: line data width.

- clock  input  1  rising-edge clock.
- resetn  input  1  synchronous reset, active-low.
- missReq  input  1  miss request; sampled only in IDLE.
- missTag  input  TAG_W  line address of the missing line; captured with missReq.
- dirty  input  4  per-way dirty bits from the dirty tracker.
- victimTag  input  TAG_W  tag of the way selected by victimWay; combinational array read.
- victimData  input  DATA_W  data of the way selected by victimWay.
- victimWay  output  2  current victim way index (round-robin pointer).
- ramReq  output  1  RAM request; held until ramAck.
- ramWe  output  1  1 = write-back, 0 = fetch; valid while ramReq=1.
- ramAddr  output  TAG_W  RAM line address.
- ramWData  output  DATA_W  write-back data.
- ramRData  input  DATA_W  fetch data; valid in the ramAck cycle.
- ramAck  input  1  single-cycle RAM completion.
- cacheWe  output  4  one-hot cache line write, pulses for one cycle.
- cacheClean  output  1  high with cacheWe: line comes from RAM, dirty bit must clear.
- cacheTag  output  TAG_W  tag written with cacheWe (= captured missTag).
- cacheWData  output  DATA_W  data written with cacheWe.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse, coincident with cacheWe.

## Operation
- States: IDLE, SELECT, WB, FILL, COMMIT.
- IDLE: when missReq=1, capture missTag and go to SELECT. Otherwise stay.
- SELECT (1 cycle): capture victimTag and victimData. If dirty[victimWay]=1, go to WB; else go to FILL.
- WB: ramReq=1, ramWe=1, ramAddr=captured victimTag, ramWData=captured victimData. On ramAck go to FILL.
- FILL: ramReq=1, ramWe=0, ramAddr=captured missTag. On ramAck capture ramRData and go to COMMIT.
- COMMIT (1 cycle): cacheWe=one-hot(victimWay), cacheClean=1, cacheTag=missTag, cacheWData=fetched data, done=1. The victim pointer increments mod 4 (3→0). Go to IDLE.
- Victim pointer changes only in COMMIT. victimWay is stable from SELECT through COMMIT.
- missReq outside IDLE is ignored and not queued. A new miss is accepted in the cycle after COMMIT at the earliest.
- ramAck outside WB/FILL is ignored.
- ramAddr, ramWData and ramWe are held constant while ramReq=1.
- Reset values (resetn=0 at a clock edge, from any state, mid-transaction included):
  - state = IDLE; victim pointer = 0.
  - All outputs are 0: ramReq, ramWe, ramAddr, ramWData, cacheWe, cacheClean, cacheTag, cacheWData, busy, done.
  - A pending RAM transaction is abandoned. No cacheWe is issued.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from ramAck to ramReq.
- Clean miss, missReq at cycle 0:
  - SELECT at cycle 1.
  - FILL with ramReq=1 from cycle 2.
  - ramAck at cycle 2+L (L≥0); COMMIT at cycle 3+L; busy drops at cycle 4+L.
- Dirty miss: WB is inserted after SELECT. With write latency Lw and read latency Lr, COMMIT occurs at cycle 4+Lw+Lr.
- ramAck is accepted in the first cycle ramReq is high (L=0).
- ramReq deasserts in the cycle after ramAck. Between WB and FILL it stays high, but ramWe and ramAddr switch.

## Test plan
- Clean miss: resetn released, dirty=0000, missReq with missTag=0x12, ramAck two cycles after ramReq, ramRData=0xA5 → no write ramReq; fetch at ramAddr=0x12; then cacheWe=0001, cacheClean=1, cacheTag=0x12, cacheWData=0xA5, done=1; next victimWay=1.
- Dirty miss: victimWay=1, dirty=0010, victimTag=0x34, victimData=0x5A, missTag=0x56 → WB at ramAddr=0x34 with ramWData=0x5A and ramWe=1; then fetch at 0x56; then cacheWe=0010 with cacheClean=1.
- Round-robin wrap: five consecutive clean misses → cacheWe sequence 0001, 0010, 0100, 1000, 0001.
- Ignored inputs: missReq pulsed during FILL, and a stray ramAck in IDLE → no extra transaction; state and pointer unchanged.
- Reset mid-WB: resetn=0 while ramReq=1, ramWe=1 → next cycle all outputs are 0, busy=0, victimWay=0, and no cacheWe is issued.
- Zero-latency RAM: ramAck tied high on request → clean miss completes with done at cycle 3 after missReq.
